// File: rtl/pipeline_hazard_controller_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller_pkg
//   Shared pipeline constants: controller state encoding, counter widths,
//   the per-cycle stage-control bundle and the load-use hazard detector.
// -----------------------------------------------------------------------------
package pipeline_hazard_controller_pkg;

    localparam int PERF_CNT_W  = 16;  // performance counter width
    localparam int FLUSH_CNT_W = 3;   // holds FLUSH_DEPTH-1 for depths up to 7
    localparam int REG_ADDR_W  = 5;
    localparam int LOAD_CODE_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hazard_state_e;

    // One bit per stage-control output, in a fixed order.
    typedef struct packed {
        logic stall_pc;
        logic stall_fetch;
        logic clear_fetch;
        logic stall_dec;
        logic clear_dec;
        logic stall_ex;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NONE = '0;

    // Data-cache miss: freeze every stage, clear nothing.
    localparam stage_ctrl_t CTRL_HOLD_ALL = '{
        stall_pc: 1'b1, stall_fetch: 1'b1, clear_fetch: 1'b0,
        stall_dec: 1'b1, clear_dec: 1'b0, stall_ex: 1'b1
    };

    // Taken branch: squash the two wrong-path instructions.
    localparam stage_ctrl_t CTRL_FLUSH = '{
        stall_pc: 1'b0, stall_fetch: 1'b0, clear_fetch: 1'b1,
        stall_dec: 1'b0, clear_dec: 1'b1, stall_ex: 1'b0
    };

    // Load-use or I-cache miss: hold the front end and push a bubble
    // into execution while the older instructions keep moving.
    localparam stage_ctrl_t CTRL_BUBBLE = '{
        stall_pc: 1'b1, stall_fetch: 1'b1, clear_fetch: 1'b0,
        stall_dec: 1'b0, clear_dec: 1'b1, stall_ex: 1'b0
    };

    // A load whose destination is read by the very next instruction.
    // x0 is hard-wired to zero, so a load into it never creates a hazard.
    function automatic logic load_use_hazard(
        input logic [LOAD_CODE_W-1:0] load_code,
        input logic                   rd_we,
        input logic [REG_ADDR_W-1:0]  rd,
        input logic [REG_ADDR_W-1:0]  rs1,
        input logic [REG_ADDR_W-1:0]  rs2
    );
        return (load_code != '0) && rd_we && (rd != '0) &&
               ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_saturating_counter.sv
// -----------------------------------------------------------------------------
// saturating_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk_i    : clock
//   clear_i  : synchronous clear (highest priority)
//   enable_i : count this cycle
//   count_o  : current count
// -----------------------------------------------------------------------------
module saturating_counter
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int WIDTH = PERF_CNT_W
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: state registers are written with <= so every flop samples the
    // pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//   Resolves data-cache misses, taken branches, load-use hazards and
//   instruction-cache misses for a five-stage pipeline. Stage controls are
//   combinational from the current state and inputs; state and the two
//   performance counters are registered.
//
//   Parameters: HIGH/LOW (asserted/deasserted level), FLUSH_DEPTH (1..7
//   cycles of fetch/decode clearing per taken branch).
//
//   CLK, RST                          : clock, synchronous active-high reset
//   DEC_RS1_ADDRESS, DEC_RS2_ADDRESS  : sources of instruction entering decode
//   EX_RD_ADDRESS, EX_RD_WRITE_ENABLE : destination of instruction in decode
//                                       output register
//   EX_DATA_CACHE_LOAD                : its load code, nonzero = load
//   BRANCH_TAKEN                      : control transfer resolved taken
//   INSTRUCTION_CACHE_READY,
//   DATA_CACHE_READY                  : cache hit/ready
//   STALL_*/CLEAR_*                   : per-stage stall and clear controls
//   STALL_CYCLE_COUNT                 : cycles with the PC stalled
//   FLUSH_CYCLE_COUNT                 : cycles with fetch cleared
// -----------------------------------------------------------------------------
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter logic        HIGH        = 1'b1,
    parameter logic        LOW         = 1'b0,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [REG_ADDR_W-1:0]  DEC_RS1_ADDRESS,
    input  logic [REG_ADDR_W-1:0]  DEC_RS2_ADDRESS,
    input  logic [REG_ADDR_W-1:0]  EX_RD_ADDRESS,
    input  logic                   EX_RD_WRITE_ENABLE,
    input  logic [LOAD_CODE_W-1:0] EX_DATA_CACHE_LOAD,
    input  logic                   BRANCH_TAKEN,
    input  logic                   INSTRUCTION_CACHE_READY,
    input  logic                   DATA_CACHE_READY,
    output logic                   STALL_PROGRAM_COUNTER,
    output logic                   STALL_FETCH_STAGE,
    output logic                   CLEAR_FETCH_STAGE,
    output logic                   STALL_DECODING_STAGE,
    output logic                   CLEAR_DECODING_STAGE,
    output logic                   STALL_EXECUTION_STAGE,
    output logic [PERF_CNT_W-1:0]  STALL_CYCLE_COUNT,
    output logic [PERF_CNT_W-1:0]  FLUSH_CYCLE_COUNT
);

    // Cycles still to flush after the branch cycle itself.
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_DEPTH - 1);

    hazard_state_e            state_q, state_d;
    logic [FLUSH_CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    stage_ctrl_t              ctrl;
    stage_ctrl_t              ctrl_out;

    logic dcache_miss;
    logic icache_miss;
    logic branch;
    logic load_use;

    assign dcache_miss = (DATA_CACHE_READY != HIGH);
    assign icache_miss = (INSTRUCTION_CACHE_READY != HIGH);
    assign branch      = (BRANCH_TAKEN == HIGH);
    assign load_use    = load_use_hazard(EX_DATA_CACHE_LOAD,
                                         EX_RD_WRITE_ENABLE == HIGH,
                                         EX_RD_ADDRESS,
                                         DEC_RS1_ADDRESS,
                                         DEC_RS2_ADDRESS);

    // Next-state and stage-control decode, in priority order.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        ctrl        = CTRL_NONE;

        if (dcache_miss) begin
            // The memory stage cannot complete: freeze the whole pipe. A flush
            // in progress is paused with its remaining count intact.
            ctrl = CTRL_HOLD_ALL;
            if (state_q != ST_FLUSH) begin
                state_d = ST_MEM_WAIT;
            end
        end else if (state_q == ST_FLUSH) begin
            ctrl = CTRL_FLUSH;
            if (branch) begin
                // A new taken branch restarts the flush window.
                flush_cnt_d = FLUSH_RELOAD;
            end else begin
                flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end
            end
        end else begin
            // RUN, and MEM_WAIT on the cycle the data cache comes back,
            // share the same rules (the unused encoding also lands here).
            state_d = ST_RUN;
            if (branch) begin
                ctrl = CTRL_FLUSH;
                if (FLUSH_DEPTH > 1) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_RELOAD;
                end
            end else if (load_use || icache_miss) begin
                ctrl = CTRL_BUBBLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset silences every stage control in the same cycle.
    assign ctrl_out = RST ? CTRL_NONE : ctrl;

    assign STALL_PROGRAM_COUNTER = ctrl_out.stall_pc    ? HIGH : LOW;
    assign STALL_FETCH_STAGE     = ctrl_out.stall_fetch ? HIGH : LOW;
    assign CLEAR_FETCH_STAGE     = ctrl_out.clear_fetch ? HIGH : LOW;
    assign STALL_DECODING_STAGE  = ctrl_out.stall_dec   ? HIGH : LOW;
    assign CLEAR_DECODING_STAGE  = ctrl_out.clear_dec   ? HIGH : LOW;
    assign STALL_EXECUTION_STAGE = ctrl_out.stall_ex    ? HIGH : LOW;

    saturating_counter #(
        .WIDTH (PERF_CNT_W)
    ) u_stall_cycle_cnt (
        .clk_i    (CLK),
        .clear_i  (RST),
        .enable_i (ctrl_out.stall_pc),
        .count_o  (STALL_CYCLE_COUNT)
    );

    saturating_counter #(
        .WIDTH (PERF_CNT_W)
    ) u_flush_cycle_cnt (
        .clk_i    (CLK),
        .clear_i  (RST),
        .enable_i (ctrl_out.clear_fetch),
        .count_o  (FLUSH_CYCLE_COUNT)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//   Directed scenario tasks with expected-value tables, then randomized
//   traffic against a small behavioural model, then counter saturation.
//   Control outputs are viewed as {stall_pc, stall_fetch, clear_fetch,
//   stall_dec, clear_dec, stall_ex}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    localparam int DEPTH = 2;

    // Expected control patterns.
    localparam logic [5:0] O_NONE   = 6'b000000;
    localparam logic [5:0] O_HOLD   = 6'b110101;
    localparam logic [5:0] O_FLUSH  = 6'b001010;
    localparam logic [5:0] O_BUBBLE = 6'b110010;

    // Stimulus codes {rst, branch, icache_ready, dcache_ready, load_use}.
    localparam logic [4:0] S_IDLE    = 5'b00110;
    localparam logic [4:0] S_RST     = 5'b10110;
    localparam logic [4:0] S_RST_ALL = 5'b11001;
    localparam logic [4:0] S_BR      = 5'b01110;
    localparam logic [4:0] S_LU      = 5'b00111;
    localparam logic [4:0] S_BR_LU   = 5'b01111;
    localparam logic [4:0] S_DM      = 5'b00100;
    localparam logic [4:0] S_DM_ALL  = 5'b01101;
    localparam logic [4:0] S_IM      = 5'b00010;

    logic        CLK;
    logic        RST;
    logic [4:0]  DEC_RS1_ADDRESS;
    logic [4:0]  DEC_RS2_ADDRESS;
    logic [4:0]  EX_RD_ADDRESS;
    logic        EX_RD_WRITE_ENABLE;
    logic [2:0]  EX_DATA_CACHE_LOAD;
    logic        BRANCH_TAKEN;
    logic        INSTRUCTION_CACHE_READY;
    logic        DATA_CACHE_READY;
    logic        STALL_PROGRAM_COUNTER;
    logic        STALL_FETCH_STAGE;
    logic        CLEAR_FETCH_STAGE;
    logic        STALL_DECODING_STAGE;
    logic        CLEAR_DECODING_STAGE;
    logic        STALL_EXECUTION_STAGE;
    logic [15:0] STALL_CYCLE_COUNT;
    logic [15:0] FLUSH_CYCLE_COUNT;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_controller #(
        .HIGH        (1'b1),
        .LOW         (1'b0),
        .FLUSH_DEPTH (DEPTH)
    ) dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .DEC_RS1_ADDRESS         (DEC_RS1_ADDRESS),
        .DEC_RS2_ADDRESS         (DEC_RS2_ADDRESS),
        .EX_RD_ADDRESS           (EX_RD_ADDRESS),
        .EX_RD_WRITE_ENABLE      (EX_RD_WRITE_ENABLE),
        .EX_DATA_CACHE_LOAD      (EX_DATA_CACHE_LOAD),
        .BRANCH_TAKEN            (BRANCH_TAKEN),
        .INSTRUCTION_CACHE_READY (INSTRUCTION_CACHE_READY),
        .DATA_CACHE_READY        (DATA_CACHE_READY),
        .STALL_PROGRAM_COUNTER   (STALL_PROGRAM_COUNTER),
        .STALL_FETCH_STAGE       (STALL_FETCH_STAGE),
        .CLEAR_FETCH_STAGE       (CLEAR_FETCH_STAGE),
        .STALL_DECODING_STAGE    (STALL_DECODING_STAGE),
        .CLEAR_DECODING_STAGE    (CLEAR_DECODING_STAGE),
        .STALL_EXECUTION_STAGE   (STALL_EXECUTION_STAGE),
        .STALL_CYCLE_COUNT       (STALL_CYCLE_COUNT),
        .FLUSH_CYCLE_COUNT       (FLUSH_CYCLE_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [5:0] outs();
        return {STALL_PROGRAM_COUNTER, STALL_FETCH_STAGE, CLEAR_FETCH_STAGE,
                STALL_DECODING_STAGE, CLEAR_DECODING_STAGE, STALL_EXECUTION_STAGE};
    endfunction

    task automatic set_idle();
        RST                     = 1'b0;
        DEC_RS1_ADDRESS         = 5'd1;
        DEC_RS2_ADDRESS         = 5'd2;
        EX_RD_ADDRESS           = 5'd3;
        EX_RD_WRITE_ENABLE      = 1'b0;
        EX_DATA_CACHE_LOAD      = 3'd0;
        BRANCH_TAKEN            = 1'b0;
        INSTRUCTION_CACHE_READY = 1'b1;
        DATA_CACHE_READY        = 1'b1;
    endtask

    task automatic apply(input logic [4:0] s);
        set_idle();
        RST                     = s[4];
        BRANCH_TAKEN            = s[3];
        INSTRUCTION_CACHE_READY = s[2];
        DATA_CACHE_READY        = s[1];
        if (s[0]) begin
            // lw x5 followed by an instruction reading x5 as rs1
            EX_RD_ADDRESS      = 5'd5;
            EX_RD_WRITE_ENABLE = 1'b1;
            EX_DATA_CACHE_LOAD = 3'b010;
            DEC_RS1_ADDRESS    = 5'd5;
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are
    // sampled 3 units later, well before the next edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        apply(S_RST);
        next_cycle();
    endtask

    task automatic test_reset();
        logic [10:0] seq [2];
        seq = '{{S_RST_ALL, O_NONE}, {S_IDLE, O_NONE}};
        foreach (seq[i]) begin
            apply(seq[i][10:6]);
            settle();
            if (outs() !== seq[i][5:0]) begin
                errors++;
                $display("FAIL reset cycle %0d: outs=%b expected=%b", i, outs(), seq[i][5:0]);
            end
            checks++;
            next_cycle();
        end
        set_idle();
        settle();
        if ({STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: stall=%0d flush=%0d expected 0/0",
                     STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [10:0] seq [2];
        do_reset();
        seq = '{{S_LU, O_BUBBLE}, {S_IDLE, O_NONE}};
        foreach (seq[i]) begin
            apply(seq[i][10:6]);
            settle();
            if (outs() !== seq[i][5:0]) begin
                errors++;
                $display("FAIL load_use cycle %0d: outs=%b expected=%b", i, outs(), seq[i][5:0]);
            end
            checks++;
            if (i == 0 && STALL_CYCLE_COUNT !== 16'd0) begin
                errors++;
                $display("FAIL load_use_count_before: stall=%0d expected 0", STALL_CYCLE_COUNT);
            end
            if (i == 0) checks++;
            next_cycle();
        end
        set_idle();
        settle();
        if (STALL_CYCLE_COUNT !== 16'd1 || FLUSH_CYCLE_COUNT !== 16'd0) begin
            errors++;
            $display("FAIL load_use_counters: stall=%0d flush=%0d expected 1/0",
                     STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_no_hazard_loads();
        // Matching register but no hazard: load to x0, no write enable, not a load.
        logic [5:0] variants [3];
        variants = '{{5'd0, 1'b1}, {5'd7, 1'b0}, {5'd9, 1'b1}};
        do_reset();
        foreach (variants[i]) begin
            set_idle();
            EX_RD_ADDRESS      = variants[i][5:1];
            EX_RD_WRITE_ENABLE = variants[i][0];
            EX_DATA_CACHE_LOAD = (i == 2) ? 3'd0 : 3'b100;
            DEC_RS1_ADDRESS    = variants[i][5:1];
            DEC_RS2_ADDRESS    = variants[i][5:1];
            settle();
            if (outs() !== O_NONE) begin
                errors++;
                $display("FAIL no_hazard variant %0d: outs=%b expected=%b", i, outs(), O_NONE);
            end
            checks++;
            next_cycle();
        end
        set_idle();
        settle();
        if (STALL_CYCLE_COUNT !== 16'd0) begin
            errors++;
            $display("FAIL no_hazard_counter: stall=%0d expected 0", STALL_CYCLE_COUNT);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_branch_flush();
        logic [10:0] seq [7];
        do_reset();
        // single branch, then a second branch arriving inside the flush window
        seq = '{{S_BR, O_FLUSH}, {S_IDLE, O_FLUSH}, {S_IDLE, O_NONE},
                {S_BR, O_FLUSH}, {S_BR, O_FLUSH}, {S_IDLE, O_FLUSH},
                {S_IDLE, O_NONE}};
        foreach (seq[i]) begin
            apply(seq[i][10:6]);
            settle();
            if (outs() !== seq[i][5:0]) begin
                errors++;
                $display("FAIL branch_flush cycle %0d: outs=%b expected=%b", i, outs(), seq[i][5:0]);
            end
            checks++;
            if (i == 2 && FLUSH_CYCLE_COUNT !== 16'd2) begin
                errors++;
                $display("FAIL branch_flush_count: flush=%0d expected 2", FLUSH_CYCLE_COUNT);
            end
            if (i == 2) checks++;
            next_cycle();
        end
        set_idle();
        settle();
        if (FLUSH_CYCLE_COUNT !== 16'd5 || STALL_CYCLE_COUNT !== 16'd0) begin
            errors++;
            $display("FAIL branch_reload_counters: flush=%0d stall=%0d expected 5/0",
                     FLUSH_CYCLE_COUNT, STALL_CYCLE_COUNT);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_dcache_priority();
        logic [10:0] seq [6];
        do_reset();
        // miss concurrent with load-use and branch; branch flush on release
        seq = '{{S_DM_ALL, O_HOLD}, {S_DM_ALL, O_HOLD}, {S_DM_ALL, O_HOLD},
                {S_BR_LU, O_FLUSH}, {S_IDLE, O_FLUSH}, {S_IDLE, O_NONE}};
        foreach (seq[i]) begin
            apply(seq[i][10:6]);
            settle();
            if (outs() !== seq[i][5:0]) begin
                errors++;
                $display("FAIL dcache_priority cycle %0d: outs=%b expected=%b", i, outs(), seq[i][5:0]);
            end
            checks++;
            next_cycle();
        end
        set_idle();
        settle();
        if (STALL_CYCLE_COUNT !== 16'd3 || FLUSH_CYCLE_COUNT !== 16'd2) begin
            errors++;
            $display("FAIL dcache_priority_counters: stall=%0d flush=%0d expected 3/2",
                     STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_miss_sequences();
        logic [10:0] seq [8];
        do_reset();
        // release cycle evaluates RUN rules (I-cache miss), then a miss
        // that pauses a flush part-way through
        seq = '{{S_DM, O_HOLD}, {S_IM, O_BUBBLE}, {S_IDLE, O_NONE},
                {S_BR, O_FLUSH}, {S_DM, O_HOLD}, {S_DM, O_HOLD},
                {S_IDLE, O_FLUSH}, {S_IDLE, O_NONE}};
        foreach (seq[i]) begin
            apply(seq[i][10:6]);
            settle();
            if (outs() !== seq[i][5:0]) begin
                errors++;
                $display("FAIL miss_sequence cycle %0d: outs=%b expected=%b", i, outs(), seq[i][5:0]);
            end
            checks++;
            next_cycle();
        end
        set_idle();
        settle();
        if (STALL_CYCLE_COUNT !== 16'd4 || FLUSH_CYCLE_COUNT !== 16'd2) begin
            errors++;
            $display("FAIL miss_sequence_counters: stall=%0d flush=%0d expected 4/2",
                     STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT);
        end
        checks++;
        next_cycle();
    endtask

    task automatic test_reset_mid_flush();
        logic [10:0] seq [3];
        do_reset();
        // reset in the second flush cycle; the following cycle follows RUN
        // rules, so a load-use yields a bubble rather than a clear
        seq = '{{S_BR, O_FLUSH}, {S_RST, O_NONE}, {S_LU, O_BUBBLE}};
        foreach (seq[i]) begin
            apply(seq[i][10:6]);
            settle();
            if (outs() !== seq[i][5:0]) begin
                errors++;
                $display("FAIL reset_mid_flush cycle %0d: outs=%b expected=%b", i, outs(), seq[i][5:0]);
            end
            checks++;
            if (i == 2 && {STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT} !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_flush_counters: stall=%0d flush=%0d expected 0/0",
                         STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT);
            end
            if (i == 2) checks++;
            next_cycle();
        end
    endtask

    task automatic test_random();
        int          flush_left = 0;
        int          sc = 0;
        int          fc = 0;
        logic [5:0]  exp;
        logic        lu;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            RST                     = ($urandom_range(0, 79) == 0);
            BRANCH_TAKEN            = ($urandom_range(0, 5) == 0);
            INSTRUCTION_CACHE_READY = ($urandom_range(0, 4) != 0);
            DATA_CACHE_READY        = ($urandom_range(0, 5) != 0);
            DEC_RS1_ADDRESS         = 5'($urandom_range(0, 3));
            DEC_RS2_ADDRESS         = 5'($urandom_range(0, 3));
            EX_RD_ADDRESS           = 5'($urandom_range(0, 3));
            EX_RD_WRITE_ENABLE      = 1'($urandom_range(0, 1));
            EX_DATA_CACHE_LOAD      = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            settle();

            lu = (EX_DATA_CACHE_LOAD != 0) && EX_RD_WRITE_ENABLE && (EX_RD_ADDRESS != 0) &&
                 ((EX_RD_ADDRESS == DEC_RS1_ADDRESS) || (EX_RD_ADDRESS == DEC_RS2_ADDRESS));
            if (RST)                                 exp = O_NONE;
            else if (!DATA_CACHE_READY)              exp = O_HOLD;
            else if (flush_left > 0 || BRANCH_TAKEN) exp = O_FLUSH;
            else if (lu || !INSTRUCTION_CACHE_READY) exp = O_BUBBLE;
            else                                     exp = O_NONE;

            if (outs() !== exp) begin
                errors++;
                $display("FAIL random_outputs cycle %0d: outs=%b expected=%b", n, outs(), exp);
            end
            checks++;
            if (STALL_CYCLE_COUNT !== 16'(sc) || FLUSH_CYCLE_COUNT !== 16'(fc)) begin
                errors++;
                $display("FAIL random_counters cycle %0d: stall=%0d flush=%0d expected %0d/%0d",
                         n, STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT, sc, fc);
            end
            checks++;
            if (STALL_DECODING_STAGE === 1'b1 && CLEAR_DECODING_STAGE === 1'b1) begin
                errors++;
                $display("FAIL decode_exclusive cycle %0d: stall_dec=1 clear_dec=1 expected not both", n);
            end
            checks++;

            if (RST) begin
                flush_left = 0;
                sc = 0;
                fc = 0;
            end else begin
                if (exp[5] && sc < 65535) sc++;
                if (exp[3] && fc < 65535) fc++;
                if (DATA_CACHE_READY) begin
                    if (BRANCH_TAKEN)        flush_left = DEPTH - 1;
                    else if (flush_left > 0) flush_left--;
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        apply(S_IM);
        repeat (70000) next_cycle();
        settle();
        if (STALL_CYCLE_COUNT !== 16'hFFFF || FLUSH_CYCLE_COUNT !== 16'd0) begin
            errors++;
            $display("FAIL saturation: stall=%h flush=%0d expected ffff/0",
                     STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT);
        end
        checks++;
        if (outs() !== O_BUBBLE) begin
            errors++;
            $display("FAIL saturation_outputs: outs=%b expected=%b", outs(), O_BUBBLE);
        end
        checks++;
        set_idle();
        next_cycle();
        settle();
        if (STALL_CYCLE_COUNT !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation_hold: stall=%h expected ffff", STALL_CYCLE_COUNT);
        end
        checks++;
    endtask

    initial begin
        set_idle();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_load_use();
        test_no_hazard_loads();
        test_branch_flush();
        test_dcache_priority();
        test_miss_sequences();
        test_reset_mid_flush();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter: HIGH, 1'b1, asserted level.
REQ-002 Parameter: LOW, 1'b0, deasserted level.
REQ-003 Parameter: FLUSH_DEPTH, 2, number of cycles fetch and decode are cleared per taken branch (legal range 1..7).
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 DEC_RS1_ADDRESS, DEC_RS2_ADDRESS  in  5 each  source registers of the instruction now entering the decoding stage.
REQ-007 EX_RD_ADDRESS  in  5  destination register held in the decoding-stage output register.
REQ-008 EX_RD_WRITE_ENABLE  in  1  that instruction writes rd.
REQ-009 EX_DATA_CACHE_LOAD  in  3  that instruction's load code; nonzero means load.
REQ-010 BRANCH_TAKEN  in  1  control transfer resolved taken in execution.
REQ-011 INSTRUCTION_CACHE_READY, DATA_CACHE_READY  in  1 each  cache hit/ready.
REQ-012 STALL_PROGRAM_COUNTER, STALL_FETCH_STAGE, CLEAR_FETCH_STAGE  out  1 each.
REQ-013 STALL_DECODING_STAGE, CLEAR_DECODING_STAGE  out  1 each  drive the decoding stage's stall/clear inputs.
REQ-014 STALL_EXECUTION_STAGE  out  1  hold execution and later stages.
REQ-015 STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT  out  16 each  performance counters.

Function
REQ-016 Control outputs SHALL be combinational from current state and inputs (zero latency); state and counters SHALL be registered.
REQ-017 States SHALL be RUN, FLUSH, MEM_WAIT.
REQ-018 Priority per cycle SHALL be: data-cache miss > branch/flush > load-use > instruction-cache miss > run.
REQ-019 Data-cache miss (DATA_CACHE_READY low, any state): all STALL_* high, all CLEAR_* low; state -> MEM_WAIT unless in FLUSH, where state and flush counter hold.
REQ-020 MEM_WAIT: exits to RUN on the cycle DATA_CACHE_READY is high; that cycle's outputs SHALL be evaluated by RUN rules.
REQ-021 Branch (RUN, BRANCH_TAKEN high, no data miss): CLEAR_FETCH_STAGE and CLEAR_DECODING_STAGE high, stalls low; if FLUSH_DEPTH>1, state -> FLUSH with counter = FLUSH_DEPTH-1.
REQ-022 FLUSH: both clears high each cycle; counter decrements; counter reaching 0 returns to RUN; BRANCH_TAKEN in FLUSH SHALL reload counter to FLUSH_DEPTH-1.
REQ-023 Load-use: EX_DATA_CACHE_LOAD!=0, EX_RD_WRITE_ENABLE high, EX_RD_ADDRESS!=0 and equal to DEC_RS1_ADDRESS or DEC_RS2_ADDRESS -> STALL_PROGRAM_COUNTER, STALL_FETCH_STAGE, CLEAR_DECODING_STAGE high for exactly one cycle (bubble); STALL_DECODING_STAGE low.
REQ-024 Load to x0 SHALL NOT stall.
REQ-025 Instruction-cache miss (INSTRUCTION_CACHE_READY low, none above): STALL_PROGRAM_COUNTER, STALL_FETCH_STAGE, CLEAR_DECODING_STAGE high.
REQ-026 Never SHALL STALL_DECODING_STAGE and CLEAR_DECODING_STAGE both be high.
REQ-027 STALL_CYCLE_COUNT SHALL increment on every cycle with STALL_PROGRAM_COUNTER high; FLUSH_CYCLE_COUNT on every cycle with CLEAR_FETCH_STAGE high; both saturate at 16'hFFFF.

Reset
REQ-028 RST high SHALL force state RUN, flush counter 0, both counters 0, and all STALL_*/CLEAR_* outputs low in that cycle.
REQ-029 RST mid-FLUSH or mid-MEM_WAIT SHALL abort the sequence; the first cycle after reset SHALL evaluate RUN rules.

Structure
REQ-030 State encoding (RUN=2'd0, FLUSH=2'd1, MEM_WAIT=2'd2) and counter width SHALL live in the shared pipeline constants package.
REQ-031 One sub-module, saturating_counter (16-bit, enable, sync clear), SHALL be instantiated twice.

Verification
REQ-032 Load x5, next instruction reads rs1=x5 -> one cycle CLEAR_DECODING_STAGE=1, STALL_FETCH_STAGE=1, STALL_CYCLE_COUNT 0->1.
REQ-033 BRANCH_TAKEN 1 cycle, FLUSH_DEPTH=2 -> clears high 2 consecutive cycles, FLUSH_CYCLE_COUNT=2, state back to RUN.
REQ-034 DATA_CACHE_READY low 3 cycles concurrent with load-use and BRANCH_TAKEN -> all stalls high, no clears for 3 cycles; branch flush follows on release.
REQ-035 Load to x0 read by next instruction -> no stall, no clear.
REQ-036 RST asserted in second FLUSH cycle -> clears low that cycle, counters 0, RUN next cycle.
REQ-037 70000 stall cycles -> STALL_CYCLE_COUNT holds 16'hFFFF.
